// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED expansion-board scan receiver.
//   pixel_frame_t   : 16x16 bit frame, indexed [row][col]
//   capture_state_t : frame-assembly FSM states
//   reverse16       : bit reversal used for the column mapping (col 0 = field MSB)
package led_scan_pkg;

  localparam int unsigned NUM_ROWS = 16;
  localparam int unsigned ROW_BITS = 4;
  localparam int unsigned ROW_MSB  = 35;
  localparam int unsigned ROW_LSB  = 32;
  localparam int unsigned GRN_MSB  = 31;
  localparam int unsigned RED_MSB  = 15;

  typedef logic [15:0][15:0] pixel_frame_t;

  typedef enum logic {
    SEEK,
    CAPTURE
  } capture_state_t;

  function automatic logic [15:0] reverse16(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_row_stabiliser.sv
// Row-field qualifier for the LED scan receiver.
// Emits a one-cycle row_q_o pulse once the row field has held a value that
// differs from the last qualified row for STABLE_CYCLES consecutive samples.
// Exactly one pulse per dwell; any change restarts the count.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   row_i        : sampled row field
//   row_q_o      : qualification pulse (combinational, valid for the capture edge)
//   row_o        : qualified row value (meaningful while row_q_o is high)
module led_row_stabiliser
  import led_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ROW_BITS-1:0] row_i,
  output logic                row_q_o,
  output logic [ROW_BITS-1:0] row_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  logic [ROW_BITS-1:0] cand_q;
  logic [ROW_BITS-1:0] last_q;
  logic                last_vld_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;

  // cnt_d counts samples of the current value including this cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (row_i != cand_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q < CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // last_vld_q lets the very first row after reset qualify even if it is 0.
  assign row_q_o = (cnt_d == CW'(STABLE_CYCLES)) && (!last_vld_q || (row_i != last_q));
  assign row_o   = row_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cand_q     <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      cand_q <= row_i;
      cnt_q  <= cnt_d;
      if (row_q_o) begin
        last_q     <= row_i;
        last_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scan_capture.sv
// Receive end of the 16x16x2 LED scan interface: samples the GPIO_1 row-scan
// stream, assembles rows 0..15 into a shadow frame and commits it to
// RedPixels/GrnPixels when the next row 0 arrives after a complete pass.
// Ports:
//   Clock, RST    : clock, synchronous active-high reset
//   GPIO_1        : [35:32] row, [31:16] green, [15:0] red (col 0 = MSB of field)
//   RedPixels     : last committed red frame [row][col]
//   GrnPixels     : last committed green frame [row][col]
//   frame_valid   : 1-cycle pulse on commit
//   frame_error   : 1-cycle pulse when a partial / out-of-order frame is dropped
//   stalled       : high while no row has qualified for TIMEOUT_CYCLES cycles
//   frame_count   : committed frames, wrapping
// Build option: define LED_CAPTURE_SYNC_EN for a 2-flop input synchronizer
// (asynchronous source); otherwise a single input register is used.
module led_scan_capture
  import led_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic         Clock,
  input  logic         RST,
  input  logic [35:0]  GPIO_1,
  output pixel_frame_t RedPixels,
  output pixel_frame_t GrnPixels,
  output logic         frame_valid,
  output logic         frame_error,
  output logic         stalled,
  output logic [15:0]  frame_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [35:0] gpio_q;

`ifdef LED_CAPTURE_SYNC_EN
  logic [35:0] meta_q;
  always_ff @(posedge Clock) begin
    if (RST) begin
      meta_q <= '0;
      gpio_q <= '0;
    end else begin
      meta_q <= GPIO_1;
      gpio_q <= meta_q;
    end
  end
`else
  always_ff @(posedge Clock) begin
    if (RST) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= GPIO_1;
    end
  end
`endif

  logic                row_q;
  logic [ROW_BITS-1:0] row;

  led_row_stabiliser #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk_i  (Clock),
    .rst_i  (RST),
    .row_i  (gpio_q[ROW_MSB:ROW_LSB]),
    .row_q_o(row_q),
    .row_o  (row)
  );

  capture_state_t      state_q;
  logic [ROW_BITS-1:0] exp_row_q;
  pixel_frame_t        red_sh_q;
  pixel_frame_t        grn_sh_q;

  // The shadow is written on every qualified row, also in SEEK: a frame is
  // only committed after rows 1..15 were rewritten in order, so stale rows
  // from an abandoned pass can never reach the outputs.
  always_ff @(posedge Clock) begin
    if (RST) begin
      state_q     <= SEEK;
      exp_row_q   <= '0;
      red_sh_q    <= '0;
      grn_sh_q    <= '0;
      RedPixels   <= '0;
      GrnPixels   <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (row_q) begin
        red_sh_q[row] <= reverse16(gpio_q[RED_MSB -: 16]);
        grn_sh_q[row] <= reverse16(gpio_q[GRN_MSB -: 16]);
        case (state_q)
          SEEK: begin
            if (row == '0) begin
              state_q   <= CAPTURE;
              exp_row_q <= ROW_BITS'(1);
            end
          end
          CAPTURE: begin
            if (row == '0) begin
              // expected_row wrapped to 0 means rows 0..15 were all seen.
              if (exp_row_q == '0) begin
                RedPixels   <= red_sh_q;
                GrnPixels   <= grn_sh_q;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
              end else begin
                frame_error <= 1'b1;
              end
              exp_row_q <= ROW_BITS'(1);
            end else if (row == exp_row_q) begin
              exp_row_q <= exp_row_q + ROW_BITS'(1);
            end else begin
              frame_error <= 1'b1;
              state_q     <= SEEK;
            end
          end
          default: state_q <= SEEK;
        endcase
      end
    end
  end

  logic [TW-1:0] idle_q;
  logic [TW-1:0] idle_d;

  always_comb begin
    idle_d = idle_q;
    if (idle_q < TW'(TIMEOUT_CYCLES)) begin
      idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      idle_q  <= '0;
      stalled <= 1'b0;
    end else if (row_q) begin
      idle_q  <= '0;
      stalled <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      stalled <= (idle_d == TW'(TIMEOUT_CYCLES));
    end
  end

endmodule

// File: tb/tb_led_scan_capture.sv
module tb_led_scan_capture;
  import led_scan_pkg::*;

  localparam int unsigned DWELL = 8;

  logic         clk;
  logic         rst;
  logic [35:0]  gpio;
  pixel_frame_t red_o;
  pixel_frame_t grn_o;
  logic         fv;
  logic         fe;
  logic         stl;
  logic [15:0]  fcnt;

  led_scan_capture #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .Clock      (clk),
    .RST        (rst),
    .GPIO_1     (gpio),
    .RedPixels  (red_o),
    .GrnPixels  (grn_o),
    .frame_valid(fv),
    .frame_error(fe),
    .stalled    (stl),
    .frame_count(fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    pixel_frame_t red;
    pixel_frame_t grn;
    logic [15:0]  cnt;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  pixel_frame_t ra, ga, rb, gb, rc, gc, rd, gd, re, ge;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (fv && fe) begin
      checks++;
      errors++;
      $display("FAIL both_pulses: frame_valid=1 frame_error=1 expected not both");
    end else if (fv || fe) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b expected no pulse", fv, fe);
      end else begin
        e = q.pop_front();
        chk("pulse_is_error", 256'(fe), 256'(e.is_err));
        chk("red_frame", red_o, e.red);
        chk("grn_frame", grn_o, e.grn);
        chk("frame_count", 256'(fcnt), 256'(e.cnt));
      end
    end
  end

  task automatic push(input bit is_err, input pixel_frame_t r, input pixel_frame_t g,
                      input logic [15:0] c);
    exp_t e;
    e.is_err = is_err; e.red = r; e.grn = g; e.cnt = c;
    q.push_back(e);
  endtask

  // LED driver model: row field and column bits change together, then dwell.
  task automatic drive_row(input pixel_frame_t r, input pixel_frame_t g,
                           input logic [3:0] row, input int unsigned cycles);
    logic [35:0] v;
    v = '0;
    v[35:32] = row;
    for (int c = 0; c < 16; c++) begin
      v[31-c] = g[row][c];
      v[15-c] = r[row][c];
    end
    gpio = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scan(input pixel_frame_t r, input pixel_frame_t g,
                      input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive_row(r, g, 4'(i), DWELL);
  endtask

  task automatic idle_and_reset(input int unsigned cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    chk({tag, "_red"}, red_o, '0);
    chk({tag, "_grn"}, grn_o, '0);
    chk({tag, "_count"}, 256'(fcnt), 256'(0));
    chk({tag, "_valid"}, 256'(fv), 256'(0));
    chk({tag, "_error"}, 256'(fe), 256'(0));
    chk({tag, "_stalled"}, 256'(stl), 256'(0));
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      logic [3:0] r4;
      r4 = 4'(r);
      ra[r] = r4[0] ? 16'h5555 : 16'hAAAA;     // red[r][c] = (r^c)&1
      ga[r] = ~ra[r];
      rb[r] = 16'h0001 << r;
      gb[r] = 16'h8000 >> r;
      rc[r] = {4{r4}};
      gc[r] = 16'hA5A5 ^ {12'h000, r4};
      rd[r] = 16'hFFFF >> r;
      gd[r] = 16'h1234 + 16'(r);
      re[r] = 16'hFFFF;
      ge[r] = (r == 15) ? 16'hFFFF : 16'h0000;
    end

    // 1: reset with an idle row field
    gpio = {4'hF, 32'h0};
    rst  = 1'b0;
    @(posedge clk); #1;
    idle_and_reset(3);
    check_cleared("reset");

    // 2: checkerboard, full pass then row 0
    push(1'b0, ra, ga, 16'd1);
    scan(ra, ga, 0, 15);
    drive_row(ra, ga, 4'd0, DWELL);

    // 3: reset, then scan starting at row 7 (7..15 ignored)
    gpio = {4'hF, 32'h0};
    idle_and_reset(2);
    check_cleared("reset2");
    push(1'b0, rb, gb, 16'd1);
    scan(rb, gb, 7, 15);
    scan(rb, gb, 0, 15);
    drive_row(rc, gc, 4'd0, DWELL);

    // 4: rows 0..5 then 7 -> error, previous frame retained
    push(1'b1, rb, gb, 16'd1);
    scan(rc, gc, 1, 5);
    drive_row(rc, gc, 4'd7, DWELL);
    @(negedge clk);
    chk("after_error_red", red_o, rb);
    chk("after_error_count", 256'(fcnt), 256'(1));
    push(1'b0, rc, gc, 16'd2);
    scan(rc, gc, 0, 15);
    drive_row(rd, gd, 4'd0, DWELL);

    // 5: 3 -> 9 (2 cycles) -> 3 glitch, frame still completes
    push(1'b0, rd, gd, 16'd3);
    scan(rd, gd, 1, 2);
    drive_row(rd, gd, 4'd3, 3);
    drive_row(rd, gd, 4'd9, 2);
    drive_row(rd, gd, 4'd3, DWELL);
    scan(rd, gd, 4, 15);
    drive_row(rd, gd, 4'd0, DWELL);

    // 6: stall, resume, mid-frame reset
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("stall_before_timeout", 256'(stl), 256'(0));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_after_timeout", 256'(stl), 256'(1));
    @(posedge clk); #1;
    drive_row(rd, gd, 4'd1, 2);
    @(negedge clk);
    chk("stall_held_until_row_q", 256'(stl), 256'(1));
    drive_row(rd, gd, 4'd1, DWELL);
    @(negedge clk);
    chk("stall_cleared_on_row_q", 256'(stl), 256'(0));
    scan(rd, gd, 2, 5);
    idle_and_reset(2);
    check_cleared("reset_mid_frame");
    push(1'b0, re, ge, 16'd1);
    scan(re, ge, 6, 15);
    scan(re, ge, 0, 15);
    drive_row(re, ge, 4'd0, DWELL);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 256'(q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
